alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Parametrised successor to the combinational ALU-control decoder: decodes aluop/funct and executes the selected operation in one block.
- Single-cycle ops (add, sub, and, or, slt) plus multi-cycle ops: iterative variable shifts (sllv, srlv) and an iterative multiply (mul).
- Adds a start/ready/done handshake and an illegal-funct flag.
- Sits between the register-file read stage and writeback of the multi-cycle datapath; the main controller stalls on ready.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- SHIFT_STEP, 4, maximum bit positions shifted per cycle (power of two, 1..WIDTH).
- MUL_EN, 1, 1 = mul implemented; 0 = mul funct decodes as illegal.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in a cycle where ready=1.
- aluop  in  2  00 add, 01 sub, 11 and, 10 R-type (use funct).
- funct  in  6  R-type function code; ignored unless aluop=10.
- a  in  WIDTH  operand A (shift value for shifts).
- b  in  WIDTH  operand B (shift amount in b[log2(WIDTH)-1:0] for shifts).
- ready  out  1  high when idle and able to accept start.
- done  out  1  one-cycle pulse: result/zero/illegal valid.
- result  out  WIDTH  registered result; held until the next done.
- zero  out  1  registered (result==0), updated with result.
- illegal  out  1  registered; high with done if the funct code is undefined.

Behaviour:
- Reset (asynchronous): state=IDLE; ready=1; done=0; result=0; zero=1; illegal=0. A reset during SHIFT or MUL aborts the operation with no done pulse.
- R-type decode uses an exact 6-bit match:
  - 100000 add; 100010 sub; 100100 and; 100101 or; 101010 slt.
  - 000100 sllv; 000110 srlv; 011000 mul.
  - Any other code is illegal.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH with no overflow flag.
  - slt is signed: result = {0..0, a<b}.
  - sllv/srlv are logical shifts of a by b[log2(WIDTH)-1:0].
  - mul returns the low WIDTH bits of a*b.
- States:
  - IDLE: ready=1. On start, latch operands and op.
    - Single-cycle op or illegal code: compute and register result; done pulses next cycle; stay in IDLE.
    - Shift with amount <= SHIFT_STEP (including 0): same timing as a single-cycle op.
    - Shift with amount > SHIFT_STEP: perform the first step on the accept edge, remaining-=SHIFT_STEP, go to SHIFT.
    - mul: process b bit 0 on the accept edge, count=1, go to MUL.
  - SHIFT: ready=0. Each cycle shift by min(SHIFT_STEP, remaining). When remaining reaches 0, register result, pulse done, return to IDLE.
  - MUL: ready=0. Shift-add one multiplier bit per cycle. After bit WIDTH-1, register result, pulse done, return to IDLE.
- Latency, counted in cycles from the accept edge to the cycle in which done=1:
  - single-cycle ops: 1.
  - shifts: max(1, ceil(amount/SHIFT_STEP)).
  - mul: WIDTH.
- Back-to-back: ready=1 in the done cycle of any op, so a new start may be accepted in that cycle. Single-cycle ops sustain one result per cycle.
- start while ready=0 is ignored and not queued. Inputs are sampled only at the accept edge and may change afterwards.
- Illegal code: result=0, zero=1, illegal=1 with done.
- MUL_EN=0: mul code is illegal.
- illegal is cleared on the next legal done.

Decomposition:
- Shared package alu_pkg:
  - aluop encodings and funct code constants.
  - internal op enum (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLLV, OP_SRLV, OP_MUL, OP_ILL).
  - FSM state enum.
- One natural sub-module: alu_op_decode, purely combinational (aluop, funct, MUL_EN -> op enum).
- Datapath and FSM stay in alu_seq_unit.

Test Plan (default parameters):
- Reset pulse mid-MUL (start mul a=3 b=5, assert reset at cycle 10) -> no done; after reset ready=1, result=0, zero=1.
- aluop=10 funct=100010, a=5, b=7, start -> done next cycle, result=0xFFFFFFFE, zero=0. Then funct=101010 same operands -> result=1.
- Shift timing:
  - funct=000100, a=1, b=31 -> ready=0 until done at cycle 8 (ceil(31/4)), result=0x80000000.
  - b=0 -> done at cycle 1, result=1.
  - funct=000110, a=0x80000000, b=4 -> done at cycle 1, result=0x08000000.
- funct=011000, a=0xFFFFFFFF, b=3 -> done exactly 32 cycles after accept, result=0xFFFFFFFD. A start pulse at cycle 10 is ignored (only one done).
- Illegal codes:
  - funct=111111 -> done at cycle 1 with illegal=1, result=0, zero=1.
  - Following add a=1, b=2 -> illegal=0, result=3.
  - With MUL_EN=0, funct=011000 -> illegal=1.
- Back-to-back: start held high with aluop=00, a=i, b=i for i=1..4 on consecutive cycles -> done high 4 consecutive cycles, results 2, 4, 6, 8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: aluop/funct codes, the internal
// operation enum and the controller state enum.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_MUL  = 6'b011000;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_SLLV = 4'd5,
    OP_SRLV = 4'd6,
    OP_MUL  = 4'd7,
    OP_ILL  = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLLV) || (op == OP_SRLV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational aluop/funct decoder producing the internal operation code.
import alu_pkg::*;

module alu_op_decode #(
  parameter int MUL_EN = 1
) (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output alu_op_e    op
);

  // Exact-match decode; any unlisted R-type code is illegal.
  always_comb begin
    op = OP_ILL;
    case (aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_AND: op = OP_AND;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  op = OP_ADD;
          FUNCT_SUB:  op = OP_SUB;
          FUNCT_AND:  op = OP_AND;
          FUNCT_OR:   op = OP_OR;
          FUNCT_SLT:  op = OP_SLT;
          FUNCT_SLLV: op = OP_SLLV;
          FUNCT_SRLV: op = OP_SRLV;
          FUNCT_MUL:  op = (MUL_EN != 0) ? OP_MUL : OP_ILL;
          default:    op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shifts and an
// iterative shift-add multiplier behind a start/ready/done handshake.
import alu_pkg::*;

module alu_seq_unit #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4,
  parameter int MUL_EN     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int              SW       = $clog2(WIDTH);
  localparam logic [SW:0]     STEP_L   = (SW+1)'(SHIFT_STEP);
  localparam logic [SW-1:0]   CNT_LAST = SW'(WIDTH-1);

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic [SW:0] n,
                                                input logic left);
    logic [WIDTH-1:0] r;
    if (left) r = v << n;
    else      r = v >> n;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] single_op(input alu_op_e o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  alu_op_e op;

  alu_op_decode #(.MUL_EN(MUL_EN)) u_decode (
    .aluop (aluop),
    .funct (funct),
    .op    (op)
  );

  alu_state_e       state_r, state_nx;
  logic [WIDTH-1:0] acc_r, acc_nx;
  logic [WIDTH-1:0] mcand_r, mcand_nx;
  logic [WIDTH-1:0] mplier_r, mplier_nx;
  logic [SW:0]      rem_r, rem_nx;
  logic [SW-1:0]    cnt_r, cnt_nx;
  logic             left_r, left_nx;
  logic             ready_r, done_r, zero_r, illegal_r;
  logic             done_nx, zero_nx, illegal_nx;
  logic [WIDTH-1:0] result_r, result_nx;

  logic [SW:0]      amt;
  logic [SW:0]      step;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mul_sum;

  assign amt     = {1'b0, b[SW-1:0]};
  assign step    = (rem_r > STEP_L) ? STEP_L : rem_r;
  assign shifted = shift_by(acc_r, step, left_r);
  assign mul_sum = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});

  // Next-state and datapath decisions for every register.
  always_comb begin
    state_nx   = state_r;
    acc_nx     = acc_r;
    mcand_nx   = mcand_r;
    mplier_nx  = mplier_r;
    rem_nx     = rem_r;
    cnt_nx     = cnt_r;
    left_nx    = left_r;
    result_nx  = result_r;
    illegal_nx = illegal_r;
    done_nx    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (is_shift(op)) begin
            left_nx = (op == OP_SLLV);
            if (amt <= STEP_L) begin
              result_nx  = shift_by(a, amt, (op == OP_SLLV));
              illegal_nx = 1'b0;
              done_nx    = 1'b1;
            end else begin
              acc_nx   = shift_by(a, STEP_L, (op == OP_SLLV));
              rem_nx   = amt - STEP_L;
              state_nx = S_SHIFT;
            end
          end else if (op == OP_MUL) begin
            acc_nx    = b[0] ? a : {WIDTH{1'b0}};
            mcand_nx  = a << 1'b1;
            mplier_nx = b >> 1'b1;
            cnt_nx    = SW'(1);
            state_nx  = S_MUL;
          end else begin
            result_nx  = single_op(op, a, b);
            illegal_nx = (op == OP_ILL);
            done_nx    = 1'b1;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (rem_r <= STEP_L) begin
          result_nx  = shifted;
          illegal_nx = 1'b0;
          done_nx    = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          acc_nx = shifted;
          rem_nx = rem_r - STEP_L;
        end
      end
      S_MUL: begin
        if (cnt_r == CNT_LAST) begin
          result_nx  = mul_sum;
          illegal_nx = 1'b0;
          done_nx    = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          acc_nx    = mul_sum;
          mcand_nx  = mcand_r << 1'b1;
          mplier_nx = mplier_r >> 1'b1;
          cnt_nx    = cnt_r + SW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
    zero_nx = done_nx ? (result_nx == {WIDTH{1'b0}}) : zero_r;
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      acc_r     <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      rem_r     <= {(SW+1){1'b0}};
      cnt_r     <= {SW{1'b0}};
      left_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b1;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      acc_r     <= acc_nx;
      mcand_r   <= mcand_nx;
      mplier_r  <= mplier_nx;
      rem_r     <= rem_nx;
      cnt_r     <= cnt_nx;
      left_r    <= left_nx;
      ready_r   <= (state_nx == S_IDLE);
      done_r    <= done_nx;
      result_r  <= result_nx;
      zero_r    <= zero_nx;
      illegal_r <= illegal_nx;
    end
  end

  assign ready   = ready_r;
  assign done    = done_r;
  assign result  = result_r;
  assign zero    = zero_r;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (default parameters plus a
// MUL_EN=0 instance sharing the same stimulus).
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        ready, done, zero, illegal;
  logic [31:0] result;
  logic        ready0, done0, zero0, illegal0;
  logic [31:0] result0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .SHIFT_STEP(4), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .ready(ready), .done(done), .result(result),
    .zero(zero), .illegal(illegal)
  );

  alu_seq_unit #(.WIDTH(32), .SHIFT_STEP(4), .MUL_EN(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .ready(ready0), .done(done0), .result(result0),
    .zero(zero0), .illegal(illegal0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request; returns at cycle 1 (just after the accept edge).
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    aluop = op; funct = fn; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  int lat;
  int ndone;
  logic saw;

  initial begin
    reset = 1'b1; start = 1'b0; aluop = 2'b00; funct = 6'b000000;
    a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);

    issue(2'b00, 6'b000000, 32'd1, 32'd2);
    wait_done(lat);
    chk("pre_add_lat", 32'(lat), 32'd1);
    chk("pre_add_result", result, 32'd3);

    // Reset in the middle of a multiply
    issue(2'b10, 6'b011000, 32'd3, 32'd5);
    saw = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done === 1'b1) saw = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mrst_ready", 32'(ready), 32'd1);
    chk("mrst_result", result, 32'd0);
    chk("mrst_zero", 32'(zero), 32'd1);
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("mrst_no_done", 32'(saw), 32'd0);

    issue(2'b10, 6'b100010, 32'd5, 32'd7);
    wait_done(lat);
    chk("sub_lat", 32'(lat), 32'd1);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(zero), 32'd0);

    issue(2'b10, 6'b101010, 32'd5, 32'd7);
    wait_done(lat);
    chk("slt_result", result, 32'd1);

    issue(2'b10, 6'b000100, 32'd1, 32'd31);
    chk("sllv31_busy", 32'(ready), 32'd0);
    wait_done(lat);
    chk("sllv31_lat", 32'(lat), 32'd8);
    chk("sllv31_result", result, 32'h8000_0000);
    chk("sllv31_ready", 32'(ready), 32'd1);

    issue(2'b10, 6'b000100, 32'd1, 32'd0);
    wait_done(lat);
    chk("sllv0_lat", 32'(lat), 32'd1);
    chk("sllv0_result", result, 32'd1);

    issue(2'b10, 6'b000110, 32'h8000_0000, 32'd4);
    wait_done(lat);
    chk("srlv4_lat", 32'(lat), 32'd1);
    chk("srlv4_result", result, 32'h0800_0000);

    issue(2'b10, 6'b000100, 32'd1, 32'd5);
    wait_done(lat);
    chk("sllv5_lat", 32'(lat), 32'd2);
    chk("sllv5_result", result, 32'd32);

    // Multiply with a stray start at cycle 10 that must be ignored
    issue(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'd3);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 10) begin
        aluop = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("mul_lat", 32'(lat), 32'd32);
    chk("mul_result", result, 32'hFFFF_FFFD);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("mul_single_done", 32'(ndone), 32'd0);

    issue(2'b10, 6'b111111, 32'd9, 32'd9);
    wait_done(lat);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_result", result, 32'd0);
    chk("ill_zero", 32'(zero), 32'd1);

    issue(2'b00, 6'b111111, 32'd1, 32'd2);
    wait_done(lat);
    chk("clr_illegal", 32'(illegal), 32'd0);
    chk("clr_result", result, 32'd3);

    issue(2'b10, 6'b011000, 32'd3, 32'd5);
    chk("nomul_done", 32'(done0), 32'd1);
    chk("nomul_illegal", 32'(illegal0), 32'd1);
    chk("nomul_result", result0, 32'd0);
    wait_done(lat);
    chk("mul15_result", result, 32'd15);

    // Back-to-back adds, one accepted per cycle
    @(negedge clk);
    aluop = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_result", result, 32'(2 * i));
      a = 32'(i + 1); b = 32'(i + 1);
      if (i == 4) start = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_end", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
